load_unit: RTL

Multi-cycle load path between the ALU address output and the data BRAM read port. It accepts one load request at a time and issues one or two synchronous BRAM word reads. It then extracts, aligns and sign- or zero-extends the addressed byte, halfword or word for register write-back. It is the read-side counterpart of the store byte-enable path, and it transparently splits halfword and word accesses that straddle a word boundary.

---
 rtl/load_unit_pkg.sv | 41 ++++
 rtl/load_extend.sv | 30 +++
 rtl/load_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/load_unit_pkg.sv
// Shared constants, load func3 codes, FSM encodings and request helpers for the
// data-BRAM load path.
package load_unit_pkg;

  localparam int ADDR_WIDTH_P = 12;
  localparam int DATA_WIDTH_P = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_LO = 2'd1;
  localparam logic [1:0] S_RD_HI = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [2:0] func3;
    logic [1:0] offset;
    logic       split;
  } ld_req_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_legal = 1'b1;
      default:                             f3_legal = 1'b0;
    endcase
  endfunction

  // True when offset + size runs past the end of the addressed word.
  function automatic logic f3_split(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: f3_split = (off == 2'd3);
      F3_LW:         f3_split = (off != 2'd0);
      default:       f3_split = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword/word extraction and sign/zero extension from a
// little-endian two-word window.
module load_extend
  import load_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_P
) (
  input  logic [2*DATA_WIDTH-1:0] pair_i,
  input  logic [1:0]              offset_i,
  input  logic [2:0]              func3_i,
  output logic [DATA_WIDTH-1:0]   data_o
);

  logic [DATA_WIDTH-1:0] win;

  assign win = DATA_WIDTH'(pair_i >> {offset_i, 3'b000});

  always_comb begin
    data_o = '0;
    case (func3_i)
      F3_LB:  data_o = {{(DATA_WIDTH-8){win[7]}}, win[7:0]};
      F3_LH:  data_o = {{(DATA_WIDTH-16){win[15]}}, win[15:0]};
      F3_LW:  data_o = win;
      F3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, win[7:0]};
      F3_LHU: data_o = {{(DATA_WIDTH-16){1'b0}}, win[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load FSM: issues one or two BRAM word reads per request, splitting
// accesses that cross a word boundary, and registers the extended result.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_P,
  parameter int DATA_WIDTH = DATA_WIDTH_P
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_func3,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic                  mem_r_enb,
  input  logic [DATA_WIDTH-1:0] mem_r_dat,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_err,
  output logic                  busy
);

  logic [1:0]            state_q, state_d;
  ld_req_t               req_q;
  logic [ADDR_WIDTH-3:0] waddr_q;
  logic [DATA_WIDTH-1:0] lo_word_q, lo_word_d;
  logic [DATA_WIDTH-1:0] hi_word_q, hi_word_d;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  load_valid_q, load_err_q;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  acc_legal, acc_split;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign acc_legal = f3_legal(req_func3);
  assign acc_split = f3_split(req_func3, req_addr[1:0]);

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign load_err   = load_err_q;

  // The first read goes out in the acceptance cycle so the BRAM data lands in RD_LO.
  always_comb begin
    state_d    = state_q;
    mem_r_enb  = 1'b0;
    mem_r_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && rst) begin
          if (acc_legal) begin
            mem_r_enb  = 1'b1;
            mem_r_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            state_d    = S_RD_LO;
          end else begin
            state_d    = S_DONE;
          end
        end
      end
      S_RD_LO: begin
        if (req_q.split) begin
          mem_r_enb  = 1'b1;
          mem_r_addr = {waddr_q + 1'b1, 2'b00};
          state_d    = S_RD_HI;
        end else begin
          state_d    = S_DONE;
        end
      end
      S_RD_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Extension works on the words as they will be after this edge, so the
  // result is ready in the same cycle load_valid rises.
  always_comb begin
    lo_word_d = lo_word_q;
    hi_word_d = hi_word_q;
    if (state_q == S_RD_LO) begin
      lo_word_d = mem_r_dat;
      hi_word_d = '0;
    end else if (state_q == S_RD_HI) begin
      hi_word_d = mem_r_dat;
    end
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ext (
    .pair_i  ({hi_word_d, lo_word_d}),
    .offset_i(req_q.offset),
    .func3_i (req_q.func3),
    .data_o  (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      waddr_q      <= '0;
      lo_word_q    <= '0;
      hi_word_q    <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_word_q    <= lo_word_d;
      hi_word_q    <= hi_word_d;
      load_valid_q <= (state_d == S_DONE);
      load_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_q.func3  <= req_func3;
            req_q.offset <= req_addr[1:0];
            req_q.split  <= acc_split && acc_legal;
            waddr_q      <= req_addr[ADDR_WIDTH-1:2];
            if (!acc_legal) begin
              load_data_q <= '0;
              load_err_q  <= 1'b1;
            end
          end
        end
        S_RD_LO: if (!req_q.split) load_data_q <= ext_data;
        S_RD_HI: load_data_q <= ext_data;
        default: ;
      endcase
    end
  end

endmodule
